// File: rtl/aes_round_engine.sv
// Iterative AES round engine: one full cipher round per clock over a 128-bit state,
// round keys fetched by index from an external key-schedule store in the same cycle.
module aes_round_engine #(
    parameter int NUM_ROUNDS = 10,
    parameter bit DEC_EN     = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         encrypt,
    input  logic [127:0] data_in,
    output logic [3:0]   rk_idx,
    input  logic [127:0] rk,
    output logic         busy,
    output logic         done,
    output logic [127:0] data_out
);
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [3:0] LAST_RND = 4'(NUM_ROUNDS);

    logic [0:0]   fsm_r;
    logic [3:0]   round_r;
    logic [127:0] state_r;
    logic         enc_r;
    logic         busy_r;
    logic         done_r;
    logic [127:0] data_out_r;

    logic         mode_in_s;
    logic         last_s;
    logic [127:0] sr_s;
    logic [127:0] enc_result_s;
    logic [127:0] dec_result_s;
    logic [127:0] round_result_s;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 by repeated squaring; 0 falls out as 0 without a special case
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] i;
        i = gf_inv(a);
        return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^ {i[3:0], i[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] a);
        logic [7:0] t;
        t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) begin
            o[8*k +: 8] = inv ? inv_sbox(s[8*k +: 8]) : sbox(s[8*k +: 8]);
        end
        return o;
    endfunction

    // row r rotates left by r (right by r for the inverse); byte 4c+r sits at row r, column c
    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((inv ? (c + 4 - r) : (c + r)) % 4) + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = xtime(a[r]) ^ xtime(a[(r+1)%4]) ^ a[(r+1)%4]
                                        ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127-8*(4*c+j) -: 8];
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = gf_mul(a[r], 8'h0e) ^ gf_mul(a[(r+1)%4], 8'h0b)
                                        ^ gf_mul(a[(r+2)%4], 8'h0d) ^ gf_mul(a[(r+3)%4], 8'h09);
            end
        end
        return o;
    endfunction

    assign mode_in_s = encrypt | ~DEC_EN;
    assign last_s    = (round_r == LAST_RND);

    // forward round; the final round drops MixColumns
    always_comb begin
        sr_s = shift_rows(sub_bytes(state_r, 1'b0), 1'b0);
        if (last_s) begin
            enc_result_s = sr_s ^ rk;
        end else begin
            enc_result_s = mix_columns(sr_s) ^ rk;
        end
    end

    generate
        if (DEC_EN) begin : g_dec
            logic [127:0] dec_add_s;
            // inverse round; key is added before InvMixColumns, which the final round drops
            always_comb begin
                dec_add_s = sub_bytes(shift_rows(state_r, 1'b1), 1'b1) ^ rk;
                if (last_s) begin
                    dec_result_s = dec_add_s;
                end else begin
                    dec_result_s = inv_mix_columns(dec_add_s);
                end
            end
        end else begin : g_enc_only
            assign dec_result_s = enc_result_s;
        end
    endgenerate

    assign round_result_s = enc_r ? enc_result_s : dec_result_s;

    // round-key index: whitening key while idle, then walk up (encrypt) or down (decrypt)
    always_comb begin
        case (fsm_r)
            ST_IDLE: rk_idx = mode_in_s ? 4'd0 : LAST_RND;
            ST_RUN:  rk_idx = enc_r ? round_r : (LAST_RND - round_r);
            default: rk_idx = 4'd0;
        endcase
    end

    // FSM, round counter, cipher state and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_r      <= ST_IDLE;
            round_r    <= 4'd0;
            state_r    <= 128'd0;
            enc_r      <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            data_out_r <= 128'd0;
        end else begin
            done_r <= 1'b0;
            case (fsm_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= data_in ^ rk;
                        enc_r   <= mode_in_s;
                        round_r <= 4'd1;
                        busy_r  <= 1'b1;
                        fsm_r   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    state_r <= round_result_s;
                    if (last_s) begin
                        data_out_r <= round_result_s;
                        done_r     <= 1'b1;
                        busy_r     <= 1'b0;
                        round_r    <= 4'd0;
                        fsm_r      <= ST_IDLE;
                    end else begin
                        round_r <= round_r + 4'd1;
                    end
                end
                default: begin
                    fsm_r   <= ST_IDLE;
                    busy_r  <= 1'b0;
                    round_r <= 4'd0;
                end
            endcase
        end
    end

    assign busy     = busy_r;
    assign done     = done_r;
    assign data_out = data_out_r;

endmodule

// File: tb/tb_aes_round_engine.sv
// Self-checking bench for aes_round_engine: a 10-round and a 1-round instance checked every
// cycle against a table-driven AES model, plus FIPS-197 vectors and handshake corner cases.
`timescale 1ns/1ps
module tb_aes_round_engine;
    localparam int NR0 = 10;
    localparam int NR1 = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         st   [2];
    logic         enc  [2];
    logic [127:0] din  [2];
    logic [3:0]   idx  [2];
    logic [127:0] rkv  [2];
    logic         bsy  [2];
    logic         dn   [2];
    logic [127:0] dout [2];
    logic [127:0] ks   [2][16];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]   sb_t  [256];
    logic [7:0]   isb_t [256];
    logic         m_valid = 1'b0;
    logic         m_act  [2];
    logic         m_enc  [2];
    logic         m_done [2];
    int           m_rnd  [2];
    logic [127:0] m_pend [2];
    logic [127:0] m_out  [2];

    always #5 clk = ~clk;

    assign rkv[0] = ks[0][idx[0]];
    assign rkv[1] = ks[1][idx[1]];

    aes_round_engine #(.NUM_ROUNDS(NR0), .DEC_EN(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .start(st[0]), .encrypt(enc[0]), .data_in(din[0]),
        .rk_idx(idx[0]), .rk(rkv[0]), .busy(bsy[0]), .done(dn[0]), .data_out(dout[0]));

    aes_round_engine #(.NUM_ROUNDS(NR1), .DEC_EN(1'b1)) u_dut1 (
        .clk(clk), .reset(reset), .start(st[1]), .encrypt(enc[1]), .data_in(din[1]),
        .rk_idx(idx[1]), .rk(rkv[1]), .busy(bsy[1]), .done(dn[1]), .data_out(dout[1]));

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    function automatic int nr_of(input int u);
        return (u == 0) ? NR0 : NR1;
    endfunction

    // polynomial product then reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
        for (int j = 15; j >= 8; j--) if (p[j]) p = p ^ (16'h011b << (j - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] inv;
        logic [7:0] s;
        logic [7:0] c63;
        c63 = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) if (m_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8] ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c63[i];
            sb_t[x]  = s;
            isb_t[s] = 8'(x);
        end
    endtask

    function automatic logic [127:0] m_sub(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++)
            o[127-8*k -: 8] = inv ? isb_t[v[127-8*k -: 8]] : sb_t[v[127-8*k -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] m_shift(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        int src;
        for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++) begin
                src = row + 4 * ((c + (inv ? 4 - row : row)) % 4);
                o[127-8*(row+4*c) -: 8] = v[127-8*src -: 8];
            end
        return o;
    endfunction

    function automatic logic [127:0] m_mix(input logic [127:0] v, input logic inv);
        logic [127:0] o;
        logic [7:0]   cf [4];
        logic [7:0]   a  [4];
        logic [7:0]   acc;
        if (inv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     cf = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = v[127-8*(4*c+j) -: 8];
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ m_mul(cf[(j - row + 4) % 4], a[j]);
                o[127-8*(4*c+row) -: 8] = acc;
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] m_cipher(input logic [127:0] blk, input int u, input int nr, input logic e);
        logic [127:0] v;
        v = blk ^ ks[u][e ? 0 : nr];
        for (int r = 1; r <= nr; r++) begin
            if (e) begin
                v = m_shift(m_sub(v, 1'b0), 1'b0);
                if (r < nr) v = m_mix(v, 1'b0);
                v = v ^ ks[u][r];
            end else begin
                v = m_sub(m_shift(v, 1'b1), 1'b1) ^ ks[u][nr - r];
                if (r < nr) v = m_mix(v, 1'b1);
            end
        end
        return v;
    endfunction

    task automatic expand_key(input int u, input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb_t[t[31:24]], sb_t[t[23:16]], sb_t[t[15:8]], sb_t[t[7:0]]} ^ {rc, 24'h000000};
                rc = m_mul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 16; r++)
            ks[u][r] = (r <= 10) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
    endtask

    // cycle counter and behavioural model, both advanced on the active edge
    initial forever begin
        @(posedge clk);
        cyc++;
        for (int u = 0; u < 2; u++) begin
            if (reset) begin
                m_act[u] = 1'b0; m_rnd[u] = 0; m_out[u] = 128'd0; m_done[u] = 1'b0;
            end else begin
                m_done[u] = 1'b0;
                if (m_act[u]) begin
                    m_rnd[u]++;
                    if (m_rnd[u] == nr_of(u)) begin
                        m_act[u] = 1'b0; m_out[u] = m_pend[u]; m_done[u] = 1'b1;
                    end
                end else if (st[u]) begin
                    m_act[u] = 1'b1; m_rnd[u] = 0; m_enc[u] = enc[u];
                    m_pend[u] = m_cipher(din[u], u, nr_of(u), enc[u]);
                end
            end
        end
        if (reset) m_valid = 1'b1;
    end

    // every-cycle comparison of both instances against the model
    initial forever begin
        int e_idx;
        @(negedge clk);
        if (m_valid) begin
            for (int u = 0; u < 2; u++) begin
                if (m_act[u]) e_idx = m_enc[u] ? m_rnd[u] + 1 : nr_of(u) - (m_rnd[u] + 1);
                else          e_idx = enc[u] ? 0 : nr_of(u);
                chk($sformatf("u%0d_busy", u), 128'(bsy[u]), 128'(m_act[u]));
                chk($sformatf("u%0d_done", u), 128'(dn[u]), 128'(m_done[u]));
                chk($sformatf("u%0d_data_out", u), dout[u], m_out[u]);
                chk($sformatf("u%0d_rk_idx", u), 128'(idx[u]), 128'(e_idx));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic launch(input int u, input logic e, input logic [127:0] d, output int t0);
        st[u] = 1'b1; enc[u] = e; din[u] = d;
        tick();
        t0 = cyc;
        st[u] = 1'b0;
    endtask

    // lat counts cycles from the start-sampling edge to the edge closing the done cycle
    task automatic wait_done(input int u, input int t0, input int budget, output int lat);
        int k;
        k = 0;
        while (dn[u] !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        lat = (dn[u] === 1'b1) ? (cyc + 1 - t0) : -1;
    endtask

    task automatic rand_unit(input int u, input int n);
        int t0;
        int lat;
        for (int i = 0; i < n; i++) begin
            for (int r = 0; r < 16; r++) ks[u][r] = {$urandom, $urandom, $urandom, $urandom};
            launch(u, 1'($urandom_range(0, 1)), {$urandom, $urandom, $urandom, $urandom}, t0);
            if ($urandom_range(0, 2) == 0) begin
                st[u] = 1'b1; enc[u] = ~enc[u]; din[u] = {$urandom, $urandom, $urandom, $urandom};
                tick();
                st[u] = 1'b0;
            end
            wait_done(u, t0, nr_of(u) + 4, lat);
            chk($sformatf("u%0d_rand_latency", u), 128'(lat), 128'(nr_of(u) + 1));
            if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) tick();
        end
    endtask

    initial begin
        logic [127:0] pt_c, ct_c, pt_b, ct_b;
        int t0, lat, pulses;
        pt_c = 128'h00112233445566778899aabbccddeeff;
        ct_c = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        pt_b = 128'h3243f6a8885a308d313198a2e0370734;
        ct_b = 128'h3925841d02dc09fbdc118597196a0b32;
        reset = 1'b1;
        for (int u = 0; u < 2; u++) begin
            st[u] = 1'b0; enc[u] = 1'b1; din[u] = 128'd0;
            for (int r = 0; r < 16; r++) ks[u][r] = 128'd0;
        end
        build_tables();
        chk("model_gf_mul_57_83", 128'(m_mul(8'h57, 8'h83)), 128'h00c1);
        chk("model_sbox_00", 128'(sb_t[0]), 128'h0063);
        chk("model_sbox_53", 128'(sb_t[8'h53]), 128'h00ed);
        chk("model_inv_sbox_16", 128'(isb_t[8'h16]), 128'h00ff);
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("reset_busy", 128'(bsy[0]), 128'd0);
        chk("reset_done", 128'(dn[0]), 128'd0);
        chk("reset_data_out", dout[0], 128'd0);

        // FIPS-197 C.1 encrypt
        expand_key(0, 128'h000102030405060708090a0b0c0d0e0f);
        chk("model_key_round10", ks[0][10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
        chk("model_c1_encrypt", m_cipher(pt_c, 0, NR0, 1'b1), ct_c);
        launch(0, 1'b1, pt_c, t0);
        wait_done(0, t0, 20, lat);
        chk("c1_enc_latency", 128'(lat), 128'd11);
        chk("c1_enc_data_out", dout[0], ct_c);

        // decrypt with the key index walking down from 10
        tick();
        enc[0] = 1'b0;
        #1;
        chk("dec_idle_rk_idx", 128'(idx[0]), 128'd10);
        launch(0, 1'b0, ct_c, t0);
        for (int r = 1; r <= NR0; r++) begin
            chk("dec_rk_idx_seq", 128'(idx[0]), 128'(NR0 - r));
            tick();
        end
        chk("dec_done", 128'(dn[0]), 128'd1);
        chk("dec_data_out", dout[0], pt_c);

        // FIPS-197 App. B back to back, second start in the done cycle
        expand_key(0, 128'h2b7e151628aed2a6abf7158809cf4f3c);
        launch(0, 1'b1, pt_b, t0);
        wait_done(0, t0, 20, lat);
        chk("b2b_first_data_out", dout[0], ct_b);
        launch(0, 1'b1, pt_b, t0);
        wait_done(0, t0, 20, lat);
        chk("b2b_second_latency", 128'(lat), 128'd11);
        chk("b2b_second_data_out", dout[0], ct_b);

        // start at round 5 with other data is ignored
        tick();
        launch(0, 1'b1, pt_b, t0);
        repeat (4) tick();
        st[0] = 1'b1; din[0] = pt_c; enc[0] = 1'b0;
        tick();
        st[0] = 1'b0; enc[0] = 1'b1;
        wait_done(0, t0, 20, lat);
        chk("ignored_start_latency", 128'(lat), 128'd11);
        chk("ignored_start_data_out", dout[0], ct_b);

        // reset in round 4 aborts the run
        tick();
        launch(0, 1'b1, pt_b, t0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", 128'(bsy[0]), 128'd0);
        chk("abort_done", 128'(dn[0]), 128'd0);
        chk("abort_data_out", dout[0], 128'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dn[0] === 1'b1) pulses++;
        end
        chk("abort_no_done", 128'(pulses), 128'd0);
        launch(0, 1'b1, pt_b, t0);
        wait_done(0, t0, 20, lat);
        chk("after_abort_data_out", dout[0], ct_b);

        // single-round instance: last round of C.1
        ks[1][0] = 128'd0;
        ks[1][1] = 128'h13111d7fe3944a17f307a78b4d2b30c5;
        launch(1, 1'b1, 128'hbd6e7c3df2b5779e0b61216e8b10b689, t0);
        wait_done(1, t0, 6, lat);
        chk("nr1_latency", 128'(lat), 128'd2);
        chk("nr1_data_out", dout[1], ct_c);

        // randomized traffic on both instances concurrently
        tick();
        fork
            rand_unit(0, 25);
            rand_unit(1, 40);
        join
        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/aes_round_engine.md
Name: aes_round_engine

Overview:
Iterative AES cipher core that runs one full round per clock over a 128-bit state, in either encryption or decryption mode. It generalises the single combinational last-round stage into a sequenced engine with a parametrised round count and a start/done handshake. Round keys come from an external key-schedule store through a same-cycle index/data port. The engine sits between the key-schedule block and the host data path.

Parameters:
NUM_ROUNDS, 10, number of rounds; legal values 1..14 (10/12/14 for AES-128/192/256).
DEC_EN, 1, 1 = inverse-cipher datapath present; 0 = encrypt-only, and the encrypt input is ignored (treated as 1).

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request; accepted only while busy=0
encrypt  input  1  mode sampled with start: 1 = encrypt, 0 = decrypt
data_in  input  128  plaintext or ciphertext, sampled with start
rk_idx  output  4  round-key index requested this cycle (combinational)
rk  input  128  round key for rk_idx; valid in the same cycle
busy  output  1  high while rounds are in progress
done  output  1  one-cycle pulse when data_out updates
data_out  output  128  result; holds its value until the next done

Behaviour:
- One clock and one reset; reset is synchronous and active-high.
- Byte order: state byte 0 = bits [127:120]; bytes are column-major per FIPS-197. The same order applies to rk.
- Reset values: busy=0, done=0, data_out=0, state register=0, round counter=0, FSM=IDLE. Reset wins over every other input, including mid-run; the run in progress is discarded and no done is issued.
- FSM has two states, IDLE and RUN.
- IDLE:
  - rk_idx = 0 when encrypt=1, and NUM_ROUNDS when encrypt=0.
  - On start: state <= data_in XOR rk; mode latched; round counter <= 1; go to RUN; busy=1 from the next cycle.
- RUN, counter r = 1..NUM_ROUNDS; rk_idx = r for encrypt, NUM_ROUNDS-r for decrypt.
- Encrypt round: SubBytes, then ShiftRows, then MixColumns, then XOR rk. MixColumns is skipped when r = NUM_ROUNDS.
- Decrypt round: InvShiftRows, then InvSubBytes, then XOR rk, then InvMixColumns. InvMixColumns is skipped when r = NUM_ROUNDS.
- After round r = NUM_ROUNDS: data_out <= round result; done=1 for one cycle (the cycle after the final round edge); busy=0 in that same cycle; return to IDLE.
- Latency: start sampled at edge T gives done high in cycle T+NUM_ROUNDS+1. A new start is accepted in that done cycle, so back-to-back throughput is one block per NUM_ROUNDS+1 cycles.
- start while busy=1 is ignored; data_in and encrypt changes during RUN have no effect.
- S-box: GF(2^8) inverse (poly 0x11B, 0 maps to 0) plus the affine transform. The inverse S-box uses the inverse affine transform followed by the GF inverse. Both are combinational; no tables.
- MixColumns uses xtime arithmetic mod 0x11B. InvMixColumns uses coefficients 0e/0b/0d/09.
- DEC_EN=0: no inverse logic is synthesised; encrypt=0 behaves as encrypt=1.
- data_out changes only on the done cycle or on reset.

Test Plan:
- Encrypt, FIPS-197 App. C.1 (NUM_ROUNDS=10). Key schedule of 000102030405060708090a0b0c0d0e0f driven on rk per rk_idx; start with data_in=00112233445566778899aabbccddeeff -> done at start+11, data_out=69c4e0d86a7b0430d8cdb78070b4c55a.
- Decrypt, same key. data_in=69c4e0d86a7b0430d8cdb78070b4c55a, encrypt=0 -> data_out=00112233445566778899aabbccddeeff; rk_idx sequence observed as 10,9,...,0.
- Back-to-back App. B vector (key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734). Assert start on the done cycle of the previous run -> second done exactly 11 cycles later, data_out=3925841d02dc09fbdc118597196a0b32.
- start pulsed at round 5 with different data_in -> ignored; the original result and timing are unchanged.
- reset asserted at round 4 -> next cycle busy=0, done=0, data_out=0. done never pulses for the aborted run; a fresh start afterwards completes correctly.
- NUM_ROUNDS=1, encrypt. rk[0]=0, rk[1]=13111d7fe3944a17f307a78b4d2b30c5, data_in=bd6e7c3df2b5779e0b61216e8b10b689 -> data_out=69c4e0d86a7b0430d8cdb78070b4c55a at start+2.
